kv_store_arbiter: RTL
=====================

// Module: kv_store_arbiter
// PURPOSE
//  Shares one single-port key/value store (1-cycle lookup, update port) between two lookup requesters
//  and one update producer. Lookup and update are never issued to the store in the same cycle.
//  Updates are buffered in a small FIFO and drained in idle, starvation or hazard cycles.
//  Each response is routed back to the requester that issued the lookup. Sits between fetch/predict logic and the store.
// PARAMETERS
//  KEY_WIDTH    32  key width, identical to the store's key
//  VAL_WIDTH    32  value width, identical to the store's value
//  UPD_DEPTH    4   update FIFO entries, power of 2, >=2
//  STARVE_LIMIT 4   max consecutive lookup grants while the FIFO is non-empty
// PORTS
//  clk             in   1          clock
//  reset           in   1          asynchronous, active-low reset (0 = in reset)
//  rqN_valid       in   1          lookup request, N=0,1
//  rqN_ready       out  1          lookup accepted this cycle
//  rqN_key         in   KEY_WIDTH  lookup key
//  rqN_resp_valid  out  1          response for requester N
//  rqN_resp_hit    out  1          hit flag
//  rqN_resp_value  out  VAL_WIDTH  value (valid only when hit)
//  upd_valid       in   1          update push
//  upd_ready       out  1          FIFO not full
//  upd_key         in   KEY_WIDTH  update key
//  upd_value       in   VAL_WIDTH  update value
//  flush_valid     in   1          pulse: drain all buffered updates
//  flush_done      out  1          1-cycle pulse when the flush completes
//  upd_count       out  $clog2(UPD_DEPTH)+1  FIFO occupancy
//  kv_req_valid/kv_req_ready/kv_req_key               out/in/out  store lookup port
//  kv_resp_valid/kv_resp_hit/kv_resp_value            in          store response (1 cycle after the request)
//  kv_update_valid/kv_update_key/kv_update_value      out         store update port
// BEHAVIOUR
//  Reset (async assert): FIFO empty, upd_count=0, state RUN, round-robin pointer favours rq0, starve counter=0.
//   All valid/ready/done outputs are 0. The in-flight lookup and buffered updates are discarded.
//  upd_ready = (upd_count < UPD_DEPTH). A push is visible to the arbiter only from the next cycle (no same-cycle bypass).
//  Hazard: a lookup key equal to the key of any valid FIFO entry is not granted.
//  FSM RUN, per-cycle priority:
//   1 FIFO full, or starve counter == STARVE_LIMIT, or all valid lookups are hazarded -> issue the FIFO head as an update.
//   2 else any non-hazarded lookup valid and kv_req_ready -> grant one requester round-robin.
//     Pointer moves past the winner. starve counter +1 if FIFO non-empty, else 0.
//   3 else FIFO non-empty -> issue an update.
//   Issuing an update pops the FIFO and clears the starve counter.
//  rqN_ready is high only in the cycle requester N is granted (kv_req_valid=1, kv_req_key=rqN_key).
//  Owner register holds the granted requester. The next cycle: rqN_resp_* = kv_resp_* gated by owner==N.
//  Lookups pipeline back-to-back at full rate.
//  Update issue: kv_update_valid=1 for exactly one cycle per popped entry, key/value taken from the FIFO head.
//  FLUSH: flush_valid moves RUN->FLUSH. In FLUSH no lookups are granted and one update is issued per cycle.
//   When the FIFO is empty: flush_done=1 for one cycle, return to RUN. Pushes in FLUSH are accepted and also drained.
//   flush_valid with an empty FIFO -> flush_done the next cycle.
//  A simultaneous push and pop changes upd_count by 0.
//  FIFO pointers wrap modulo UPD_DEPTH.
//  kv_req_valid and kv_update_valid are never both 1 in the same cycle.
// TESTING
//  rq0 and rq1 both valid for 4 cycles, FIFO empty -> grants rq0,rq1,rq0,rq1.
//   Each resp arrives 1 cycle later on the correct port only.
//  Push 4 updates while both requesters stay valid -> FIFO full -> update issued on the next cycle.
//   upd_ready stays 0 until the first pop.
//  1 update pending, rq0 valid continuously -> exactly 4 lookups granted, then 1 update, then lookups resume.
//  Push update key=0x40, then rq0_key=0x40 -> rq0 held, update drained, then rq0 granted.
//   rq0 sees hit=1, value = pushed value (store modelled).
//  3 updates queued, flush_valid pulse -> 3 consecutive kv_update_valid cycles, flush_done on the 4th cycle, no grants.
//  Assert reset mid-lookup -> rqN_resp_valid=0, FIFO empty, upd_ready=1 after release, first grant goes to rq0.

Source files
------------

// File: rtl/kv_store_arbiter.sv
// kv_store_arbiter: shares one single-port key/value store between two lookup
// requesters and a buffered update producer. Lookups and updates never issue
// in the same cycle; updates drain on idle, starvation, hazard or flush.
module kv_store_arbiter #(
    parameter int KEY_WIDTH    = 32,
    parameter int VAL_WIDTH    = 32,
    parameter int UPD_DEPTH    = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         rq0_valid,
    output logic                         rq0_ready,
    input  logic [KEY_WIDTH-1:0]         rq0_key,
    output logic                         rq0_resp_valid,
    output logic                         rq0_resp_hit,
    output logic [VAL_WIDTH-1:0]         rq0_resp_value,
    input  logic                         rq1_valid,
    output logic                         rq1_ready,
    input  logic [KEY_WIDTH-1:0]         rq1_key,
    output logic                         rq1_resp_valid,
    output logic                         rq1_resp_hit,
    output logic [VAL_WIDTH-1:0]         rq1_resp_value,
    input  logic                         upd_valid,
    output logic                         upd_ready,
    input  logic [KEY_WIDTH-1:0]         upd_key,
    input  logic [VAL_WIDTH-1:0]         upd_value,
    input  logic                         flush_valid,
    output logic                         flush_done,
    output logic [$clog2(UPD_DEPTH):0]   upd_count,
    output logic                         kv_req_valid,
    input  logic                         kv_req_ready,
    output logic [KEY_WIDTH-1:0]         kv_req_key,
    input  logic                         kv_resp_valid,
    input  logic                         kv_resp_hit,
    input  logic [VAL_WIDTH-1:0]         kv_resp_value,
    output logic                         kv_update_valid,
    output logic [KEY_WIDTH-1:0]         kv_update_key,
    output logic [VAL_WIDTH-1:0]         kv_update_value
);
    localparam int PW = $clog2(UPD_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {RUN, FLUSH} state_e;

    state_e               state_q, state_d;
    logic [KEY_WIDTH-1:0] key_q [UPD_DEPTH];
    logic [VAL_WIDTH-1:0] val_q [UPD_DEPTH];
    logic [PW-1:0]        rd_q, wr_q;
    logic [CW-1:0]        cnt_q;
    logic                 rr_q, rr_d;        // 0: rq0 wins a tie
    logic [SW-1:0]        starve_q, starve_d;
    logic                 pend_q, owner_q;   // lookup in flight and who issued it

    logic [PW-1:0]        offs [UPD_DEPTH];
    logic [UPD_DEPTH-1:0] occ;
    logic                 hz0, hz1, ok0, ok1, all_hz, full, nempty;
    logic                 grant, win, pop, push;

    // Occupancy of each FIFO slot and key hazard against pending lookups
    always_comb begin
        hz0 = 1'b0;
        hz1 = 1'b0;
        for (int i = 0; i < UPD_DEPTH; i++) begin
            offs[i] = PW'(i) - rd_q;
            occ[i]  = {1'b0, offs[i]} < cnt_q;
            if (occ[i] && key_q[i] == rq0_key) hz0 = 1'b1;
            if (occ[i] && key_q[i] == rq1_key) hz1 = 1'b1;
        end
    end

    assign full   = (cnt_q == CW'(UPD_DEPTH));
    assign nempty = (cnt_q != '0);
    assign ok0    = rq0_valid & ~hz0;
    assign ok1    = rq1_valid & ~hz1;
    assign all_hz = (rq0_valid | rq1_valid) & ~ok0 & ~ok1;

    // Arbitration FSM: next state, grant/pop decision, round-robin and starvation
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        starve_d   = starve_q;
        grant      = 1'b0;
        win        = 1'b0;
        pop        = 1'b0;
        flush_done = 1'b0;
        if (reset) begin
            case (state_q)
                RUN: begin
                    if (flush_valid) begin
                        state_d = FLUSH;
                    end else if (nempty && (full || starve_q == SW'(STARVE_LIMIT) || all_hz)) begin
                        pop = 1'b1;
                    end else if ((ok0 | ok1) && kv_req_ready) begin
                        grant    = 1'b1;
                        win      = (ok0 & ok1) ? rr_q : ~ok0;
                        rr_d     = ~win;
                        starve_d = nempty ? starve_q + SW'(1) : '0;
                    end else if (nempty) begin
                        pop = 1'b1;
                    end
                end
                FLUSH: begin
                    if (nempty) begin
                        pop = 1'b1;
                    end else begin
                        flush_done = 1'b1;
                        state_d    = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
            if (pop) starve_d = '0;
        end
    end

    assign upd_ready       = reset & ~full;
    assign push            = upd_valid & upd_ready;
    assign upd_count       = cnt_q;

    assign kv_req_valid    = grant;
    assign kv_req_key      = win ? rq1_key : rq0_key;
    assign rq0_ready       = grant & ~win;
    assign rq1_ready       = grant & win;

    assign kv_update_valid = pop;
    assign kv_update_key   = key_q[rd_q];
    assign kv_update_value = val_q[rd_q];

    assign rq0_resp_valid  = pend_q & ~owner_q & kv_resp_valid;
    assign rq1_resp_valid  = pend_q &  owner_q & kv_resp_valid;
    assign rq0_resp_hit    = rq0_resp_valid & kv_resp_hit;
    assign rq1_resp_hit    = rq1_resp_valid & kv_resp_hit;
    assign rq0_resp_value  = rq0_resp_hit ? kv_resp_value : '0;
    assign rq1_resp_value  = rq1_resp_hit ? kv_resp_value : '0;

    // Control state; reset discards buffered updates and any in-flight lookup
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= RUN;
            rd_q     <= '0;
            wr_q     <= '0;
            cnt_q    <= '0;
            rr_q     <= 1'b0;
            starve_q <= '0;
            pend_q   <= 1'b0;
            owner_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_q     <= rd_q + PW'(pop);
            wr_q     <= wr_q + PW'(push);
            cnt_q    <= cnt_q + CW'(push) - CW'(pop);
            rr_q     <= rr_d;
            starve_q <= starve_d;
            pend_q   <= grant;
            owner_q  <= win;
        end
    end

    // FIFO storage; contents are qualified by the occupancy count only
    always_ff @(posedge clk) begin
        if (push) begin
            key_q[wr_q] <= upd_key;
            val_q[wr_q] <= upd_value;
        end
    end
endmodule
